// File: rtl/pcs_pkg.sv
// ---------------------------------------------------------------------------
// pcs_pkg
// Shared constants and helpers for the 10GBASE-R TX scrambler path.
//   SCR_SEED           scrambler state loaded on reset
//   SCR_TAP_A/B        polynomial taps (1 + x^39 + x^58)
//   SYNC_DATA/CTRL     64b/66b sync header codes
//   tx_word_t          payload carried through the output buffer
//   scramble32()       one 32-bit word of scrambling, returns {next_state, word}
//   shift_in32()       advance the state with already-scrambled bits (bypass)
// State convention: bit 0 is the most recent scrambled bit, so s_(k-39) sits
// at index 38 and s_(k-58) at index 57.
// ---------------------------------------------------------------------------
package pcs_pkg;

    localparam int SCR_LEN   = 58;
    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;

    localparam logic [SCR_LEN-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef struct packed {
        logic        bs;    // first word of a 66b block
        logic [1:0]  hdr;
        logic [31:0] data;
    } tx_word_t;

    // Bits are processed LSB first, matching transmit order.
    function automatic logic [SCR_LEN+31:0] scramble32(input logic [SCR_LEN-1:0] state,
                                                       input logic [31:0]        data);
        logic [SCR_LEN-1:0] st;
        logic [31:0]        word;
        logic               s;
        st   = state;
        word = '0;
        for (int k = 0; k < 32; k++) begin
            s       = data[k] ^ st[SCR_TAP_A-1] ^ st[SCR_TAP_B-1];
            word[k] = s;
            st      = {st[SCR_LEN-2:0], s};
        end
        return {st, word};
    endfunction

    // Treats the word as if it were scrambler output, so a later switch back
    // to scrambling continues from a state a descrambler would also hold.
    function automatic logic [SCR_LEN-1:0] shift_in32(input logic [SCR_LEN-1:0] state,
                                                      input logic [31:0]        word);
        logic [SCR_LEN-1:0] st;
        st = state;
        for (int k = 0; k < 32; k++) begin
            st = {st[SCR_LEN-2:0], word[k]};
        end
        return st;
    endfunction

endpackage

// File: rtl/pcs_skid_buffer.sv
// ---------------------------------------------------------------------------
// pcs_skid_buffer
// Two-entry (main + skid) valid/ready buffer with a registered ready.
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_valid/o_ready  upstream handshake; o_ready is high iff skid is empty
//   i_data           upstream payload
//   o_valid/i_ready  downstream handshake
//   o_data           downstream payload, driven straight from the main entry
// Payload registers are not cleared when they empty, so the output holds its
// last value rather than going to X.
// ---------------------------------------------------------------------------
module pcs_skid_buffer #(
    parameter int WIDTH = 35
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q;
    logic             in_xfer, out_xfer;

    assign in_xfer  = i_valid && rdy_q;
    assign out_xfer = main_vld_q && i_ready;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (!main_vld_q || out_xfer) begin
            // Main is free this cycle. A full skid implies ready was low,
            // so no new word can arrive at the same time.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_xfer) begin
                main_d     = i_data;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d     = i_data;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            rdy_q      <= !skid_vld_d;
        end
    end

    assign o_ready = rdy_q;
    assign o_valid = main_vld_q;
    assign o_data  = main_q;

endmodule

// File: rtl/pcs_tx_scrambler.sv
// ---------------------------------------------------------------------------
// pcs_tx_scrambler
// 64b/66b self-synchronising scrambler (1 + x^39 + x^58), 10GBASE-R TX.
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_tx_data/_sync_hdr/_valid     encoded word from the XGMII encoder
//   o_tx_trdy                      registered ready back to the encoder
//   o_tx_data/_sync_hdr/_valid     scrambled word to the gearbox
//   o_tx_block_start               output word is the first of a 66b block
//   i_gbx_trdy                     ready from the gearbox
//   i_scr_bypass                   only with PCS_SCRAMBLER_BYPASS_EN defined:
//                                  pass data through unscrambled
// The header is never scrambled and is forwarded as-is, including the
// illegal codes 00/11. Only DATA_WIDTH = 32 is supported.
// ---------------------------------------------------------------------------
module pcs_tx_scrambler
    import pcs_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    HDR_WIDTH  = 2,
    parameter int                    SCR_WIDTH  = 58,
    parameter logic [SCR_WIDTH-1:0]  SCR_SEED_P = pcs_pkg::SCR_SEED
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [HDR_WIDTH-1:0]  i_tx_sync_hdr,
    input  logic                  i_tx_data_valid,
    output logic                  o_tx_trdy,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [HDR_WIDTH-1:0]  o_tx_sync_hdr,
    output logic                  o_tx_data_valid,
    output logic                  o_tx_block_start,
`ifdef PCS_SCRAMBLER_BYPASS_EN
    input  logic                  i_scr_bypass,
`endif
    input  logic                  i_gbx_trdy
);

    logic [SCR_WIDTH-1:0]            scr_q, scr_d, scr_next;
    logic                            phase_q, phase_d;
    logic [SCR_WIDTH+DATA_WIDTH-1:0] scr_res;
    logic [DATA_WIDTH-1:0]           word_out;
    logic                            in_xfer;
    tx_word_t                        in_word, out_word;

    assign in_xfer = i_tx_data_valid && o_tx_trdy;
    assign scr_res = scramble32(scr_q, i_tx_data);

`ifdef PCS_SCRAMBLER_BYPASS_EN
    assign word_out = i_scr_bypass ? i_tx_data : scr_res[DATA_WIDTH-1:0];
    assign scr_next = i_scr_bypass ? shift_in32(scr_q, i_tx_data)
                                   : scr_res[SCR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
`else
    assign word_out = scr_res[DATA_WIDTH-1:0];
    assign scr_next = scr_res[SCR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
`endif

    // Scrambler state and word phase move only when a word is accepted.
    always_comb begin
        scr_d   = scr_q;
        phase_d = phase_q;
        if (in_xfer) begin
            scr_d   = scr_next;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            scr_q   <= SCR_SEED_P;
            phase_q <= 1'b0;
        end else begin
            scr_q   <= scr_d;
            phase_q <= phase_d;
        end
    end

    assign in_word.bs   = ~phase_q;
    assign in_word.hdr  = i_tx_sync_hdr;
    assign in_word.data = word_out;

    pcs_skid_buffer #(
        .WIDTH ($bits(tx_word_t))
    ) u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_tx_data_valid),
        .o_ready (o_tx_trdy),
        .i_data  (in_word),
        .o_valid (o_tx_data_valid),
        .i_ready (i_gbx_trdy),
        .o_data  (out_word)
    );

    assign o_tx_data        = out_word.data;
    assign o_tx_sync_hdr    = out_word.hdr;
    assign o_tx_block_start = out_word.bs;

endmodule

// File: tb/tb_pcs_tx_scrambler.sv
module tb_pcs_tx_scrambler;
    import pcs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tx_data;
    logic [1:0]  tx_hdr;
    logic        tx_vld;
    logic        trdy;
    logic [31:0] o_data;
    logic [1:0]  o_hdr;
    logic        o_vld;
    logic        o_bs;
    logic        gbx_rdy;
`ifdef PCS_SCRAMBLER_BYPASS_EN
    logic        scr_bypass = 1'b0;
`endif

    always #5 clk = ~clk;

    pcs_tx_scrambler dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_tx_data        (tx_data),
        .i_tx_sync_hdr    (tx_hdr),
        .i_tx_data_valid  (tx_vld),
        .o_tx_trdy        (trdy),
        .o_tx_data        (o_data),
        .o_tx_sync_hdr    (o_hdr),
        .o_tx_data_valid  (o_vld),
        .o_tx_block_start (o_bs),
`ifdef PCS_SCRAMBLER_BYPASS_EN
        .i_scr_bypass     (scr_bypass),
`endif
        .i_gbx_trdy       (gbx_rdy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed pairs, each started from a fresh reset. Expected values by
    // hand: the first 39 output bits see only seed ones, which cancel, so
    // word 0 equals its input. Word 1 = d1 ^ 32'h03FF_FF80 ^ (e0<<7) ^ (e0<<26).
    typedef struct {
        logic [31:0] d0; logic [1:0] h0;
        logic [31:0] d1; logic [1:0] h1;
        logic [31:0] e0; logic [31:0] e1;
    } vec_t;
    vec_t vt[4];

    // Golden scoreboard
    logic [57:0] gold_st;
    logic        gold_ph;
    logic [34:0] exp_q[$];
    logic [31:0] raw_q[$];
    logic [57:0] rx_st;
    int          rx_words;
    logic        prev_stall;
    logic [34:0] prev_word;

    task automatic gold_reset();
        gold_st    = SCR_SEED;
        gold_ph    = 1'b0;
        exp_q.delete();
        raw_q.delete();
        rx_st      = '0;   // deliberately wrong descrambler seed
        rx_words   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        tx_vld = 1'b0;
        step();
        rst = 1'b0;
        step();
        gold_reset();
    endtask

    // One cycle: drive, compare against the scoreboard, then clock.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [1:0] h, input logic g);
        logic [89:0] res;
        logic [31:0] rec;
        logic [31:0] raw;
        logic        b;
        tx_vld  = v;
        tx_data = d;
        tx_hdr  = h;
        gbx_rdy = g;
        #1;
        check("trdy_vs_occupancy", {63'd0, trdy}, {63'd0, exp_q.size() < 2});
        if (prev_stall) begin
            check("stall_hold", {28'd0, o_vld, o_bs, o_hdr, o_data}, {28'd0, 1'b1, prev_word});
        end
        if (o_vld && g) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", 64'd1, 64'd0);
            end else begin
                check("out_word", {29'd0, o_bs, o_hdr, o_data}, {29'd0, exp_q.pop_front()});
                raw = raw_q.pop_front();
                rec = '0;
                for (int k = 0; k < 32; k++) begin
                    b      = o_data[k];
                    rec[k] = b ^ rx_st[38] ^ rx_st[57];
                    rx_st  = {rx_st[56:0], b};
                end
                if (rx_words >= 2) check("descramble", {32'd0, rec}, {32'd0, raw});
                rx_words++;
            end
        end
        if (v && trdy) begin
            res     = scramble32(gold_st, d);
            exp_q.push_back({~gold_ph, h, res[31:0]});
            raw_q.push_back(d);
            gold_st = res[89:32];
            gold_ph = ~gold_ph;
        end
        prev_stall = o_vld && !g;
        prev_word  = {o_bs, o_hdr, o_data};
        step();
    endtask

    task automatic run_random(input int n, input bit stalls);
        int acc = 0;
        int cyc = 0;
        int stall_cnt = 0;
        logic v;
        logic g;
        while ((acc < n || exp_q.size() != 0) && cyc < 20000) begin
            v = (acc < n) && ($urandom_range(0, 3) != 0);
            if (stalls && stall_cnt == 0 && $urandom_range(0, 5) == 0)
                stall_cnt = $urandom_range(1, 5);
            g = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            if (v && trdy) acc++;
            cycle(v, $urandom, 2'($urandom), g);
            cyc++;
        end
        if (cyc >= 20000) check("random_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h0000_0000, SYNC_DATA, 32'h0000_0000, SYNC_CTRL, 32'h0000_0000, 32'h03FF_FF80};
        vt[1] = '{32'h0000_0001, 2'b00,     32'h0000_0000, 2'b11,     32'h0000_0001, 32'h07FF_FF00};
        vt[2] = '{32'hDEAD_BEEF, SYNC_CTRL, 32'h03FF_FF80, SYNC_DATA, 32'hDEAD_BEEF, 32'hEADF_7780};
        vt[3] = '{32'hFFFF_FFFF, 2'b11,     32'hFFFF_FFFF, 2'b00,     32'hFFFF_FFFF, 32'hFFFF_FFFF};

        rst     = 1'b1;
        tx_vld  = 1'b0;
        tx_data = '0;
        tx_hdr  = '0;
        gbx_rdy = 1'b1;
        gold_reset();
        step();
        step();
        check("reset_outputs", {28'd0, trdy, o_vld, o_bs, o_hdr, o_data}, 64'd0);
        rst = 1'b0;
        step();
        check("trdy_after_reset", {63'd0, trdy}, 64'd1);

        // Table-driven directed pairs
        for (int i = 0; i < 4; i++) begin
            do_reset();
            tx_vld  = 1'b1;
            tx_data = vt[i].d0;
            tx_hdr  = vt[i].h0;
            step();
            check($sformatf("vec%0d_w0", i), {28'd0, o_vld, o_bs, o_hdr, o_data},
                  {28'd0, 1'b1, 1'b1, vt[i].h0, vt[i].e0});
            tx_data = vt[i].d1;
            tx_hdr  = vt[i].h1;
            step();
            check($sformatf("vec%0d_w1", i), {28'd0, o_vld, o_bs, o_hdr, o_data},
                  {28'd0, 1'b1, 1'b0, vt[i].h1, vt[i].e1});
            tx_vld = 1'b0;
            step();
            check($sformatf("vec%0d_idle", i), {63'd0, o_vld}, 64'd0);
        end

        // Random traffic, gearbox always ready, then with random stalls
        do_reset();
        run_random(1000, 1'b0);
        do_reset();
        run_random(600, 1'b1);

        // Fill both entries, hold a 5-cycle stall at full occupancy, drain
        do_reset();
        cycle(1'b1, 32'h1111_1111, SYNC_DATA, 1'b0);
        cycle(1'b1, 32'h2222_2222, SYNC_CTRL, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h3333_3333, SYNC_DATA, 1'b0);
        check("full_no_ready", {63'd0, trdy}, 64'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, SYNC_DATA, 1'b1);
        check("drained", {63'd0, o_vld}, 64'd0);

        // Reset with both entries full
        cycle(1'b1, 32'hAAAA_AAAA, SYNC_DATA, 1'b0);
        cycle(1'b1, 32'h5555_5555, SYNC_DATA, 1'b0);
        check("full_before_reset", {62'd0, o_vld, trdy}, {62'd0, 1'b1, 1'b0});
        rst    = 1'b1;
        tx_vld = 1'b0;
        step();
        check("midreset_valid", {63'd0, o_vld}, 64'd0);
        rst     = 1'b0;
        gbx_rdy = 1'b1;
        step();
        gold_reset();
        tx_vld  = 1'b1;
        tx_data = 32'h0;
        tx_hdr  = SYNC_DATA;
        step();
        check("post_reset_zero", {28'd0, o_vld, o_bs, o_hdr, o_data},
              {28'd0, 1'b1, 1'b1, SYNC_DATA, 32'h0});
        tx_vld = 1'b0;
        step();

`ifdef PCS_SCRAMBLER_BYPASS_EN
        // A second word makes bypass visible: scrambled it would not be raw.
        do_reset();
        scr_bypass = 1'b1;
        tx_vld     = 1'b1;
        tx_data    = 32'hDEAD_BEEF;
        tx_hdr     = SYNC_DATA;
        step();
        check("bypass_w0", {31'd0, o_vld, o_data}, {31'd0, 1'b1, 32'hDEAD_BEEF});
        tx_data = 32'h0000_0000;
        step();
        check("bypass_w1", {31'd0, o_vld, o_data}, {31'd0, 1'b1, 32'h0000_0000});
        tx_vld     = 1'b0;
        scr_bypass = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pcs_tx_scrambler.md
Name: pcs_tx_scrambler

Overview:
- 64b/66b self-synchronising scrambler (polynomial 1 + x^39 + x^58) for the 10GBASE-R TX path.
- Sits directly downstream of the XGMII encoder. Consumes its 32-bit data, 2-bit sync header and valid, and drives backpressure to it.
- Feeds the TX gearbox with scrambled 32-bit words. Sync header passes through unscrambled.
- Each 66b block is two 32-bit words. The block tracks word phase and flags block starts.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 supported.
- HDR_WIDTH, 2, sync header width.
- SCR_WIDTH, 58, scrambler state length.
- SCR_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state loaded on reset.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous, active-high reset
- i_tx_data  in  32  encoded data word from encoder; bit 0 transmitted first
- i_tx_sync_hdr  in  2  sync header from encoder
- i_tx_data_valid  in  1  input word valid
- o_tx_trdy  out  1  ready to encoder; registered
- o_tx_data  out  32  scrambled data to gearbox
- o_tx_sync_hdr  out  2  sync header, unscrambled
- o_tx_data_valid  out  1  output word valid
- o_tx_block_start  out  1  high when the output word is the first word of a 66b block
- i_gbx_trdy  in  1  ready from gearbox

Behaviour:
- Transfers: a word transfers on input when i_tx_data_valid && o_tx_trdy. It transfers on output when o_tx_data_valid && i_gbx_trdy.
- Scrambling rule, serial model, per bit k in LSB-first order: s_k = d_k ^ s_(k-39) ^ s_(k-58). The state holds the last 58 scrambled bits.
- All 32 bits are computed combinationally from the state in one cycle. The state advances only on an input transfer.
- Header and phase are never scrambled. They are registered alongside the data.
- Word phase: a 1-bit counter, 0 after reset. It toggles on each input transfer. Phase 0 word → o_tx_block_start = 1 on that output word.
- Latency: 1 cycle from input transfer to o_tx_data_valid when the output is empty or draining.
- Buffering: 2-entry skid buffer (main + skid register).
  - o_tx_trdy = 1 iff the skid entry is empty.
  - If the output is stalled (i_gbx_trdy = 0) while a new word is accepted, that word goes to skid and o_tx_trdy drops the next cycle.
  - When the output drains, the skid word moves to main with no bubble.
- Ordering: no word is dropped, duplicated or reordered under any valid/ready pattern.
- Simultaneous input and output transfer with skid empty: main is replaced by the new word; occupancy is unchanged.
- Output values when o_tx_data_valid = 0 are don't-care but held (no X). o_tx_data is stable while valid && !i_gbx_trdy.
- Reset values:
  - o_tx_data_valid 0, o_tx_block_start 0, o_tx_data 0, o_tx_sync_hdr 0, o_tx_trdy 0.
  - o_tx_trdy rises the cycle after reset deasserts.
  - Scrambler state = SCR_SEED; phase = 0; skid empty.
- Reset mid-stream: all buffered words are discarded and state reloads the seed. Any partial block is lost; no flush is done.
- Invalid sync header (00 or 11): forwarded unchanged, no error raised. Header errors are the encoder's job.

Optional Feature:
- Macro: PCS_SCRAMBLER_BYPASS_EN.
- Defined: adds input port i_scr_bypass (1 bit).
  - When 1, data passes through unscrambled, with the same latency and handshake.
  - The scrambler state still advances using the raw data as scrambled bits, so re-enabling stays self-consistent.
- Undefined: no port is added and scrambling is always active.

Decomposition:
- Shared package pcs_pkg holds SCR_SEED, the SCR_TAP_A = 39 and SCR_TAP_B = 58 constants, and the sync header constants SYNC_DATA = 2'b01 and SYNC_CTRL = 2'b10.
- A package function scramble32(state, data) returns {next_state, scrambled_word}. The bench golden model reuses it.
- One natural sub-module: pcs_skid_buffer, parameterised on payload width (35 bits: data + header + block_start).

Test Plan:
- Reset, then input 32'h0000_0000, hdr 2'b01, gearbox ready → output 32'h0000_0000 one cycle later, because seed ones cancel for bits 0..31. o_tx_block_start = 1.
- 1000 random words with random valid, gearbox ready held at 1 → every output matches the scramble32 golden model. block_start alternates 1,0. Headers are unchanged.
- Random i_gbx_trdy stalls of 1–5 cycles, including a 5-cycle stall at full occupancy → o_tx_trdy drops within 1 cycle, no loss, order preserved, o_tx_data stable during stall.
- Descramble the output with a receive-side model after starting it from a wrong seed → the model locks after the first 58 bits, and all later words equal the input.
- Assert i_reset while both entries are full → next cycle valid = 0. First post-reset zero word outputs 32'h0000_0000 again and block_start = 1.
- With PCS_SCRAMBLER_BYPASS_EN and i_scr_bypass = 1, input 32'hDEAD_BEEF → output 32'hDEAD_BEEF with 1-cycle latency.
